fpcvt_pipe: RTL
===============

Name: fpcvt_pipe

Overview:
- Parametrised, pipelined converter from a DATA_W-bit two's-complement integer to a compact sign/exponent/mantissa float (S, E, F).
- Value represented is (-1)^S * F * 2^E.
- Successor to the fixed 12-bit combinational converter: generic widths, selectable round/truncate per sample, valid/ready streaming with backpressure, saturation flag and saturation counter.
- Sits between a sample source and any consumer of compressed samples.

Parameters:
- DATA_W, 12, input integer width (two's complement), >= MANT_W+2.
- EXP_W, 3, exponent width.
- MANT_W, 4, mantissa width.
- CNT_W, 8, width of the saturating count of saturated results.
- Elaboration-time error if DATA_W-1-MANT_W > 2^EXP_W-1. The exponent must cover the full magnitude range.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter can accept a sample this cycle.
- in_data  in  DATA_W  two's-complement sample.
- in_rnd  in  1  1 = round half-up, 0 = truncate; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_s  out  1  sign.
- out_e  out  EXP_W  exponent.
- out_f  out  MANT_W  mantissa.
- out_sat  out  1  result was clamped to max magnitude.
- sat_cnt  out  CNT_W  number of saturated results delivered; sticks at all-ones.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, out_valid=0, out_s/out_e/out_f/out_sat=0, sat_cnt=0. Reset mid-stream discards all in-flight samples.
- Transfer rule: a transfer occurs on a clock edge where valid&&ready.
  - Input accepted when in_valid&&in_ready.
  - Output consumed when out_valid&&out_ready.
- Pipeline: 3 registered stages; stage k holds vk and its data.
  - rdy3 = !v3 || out_ready
  - rdy2 = !v2 || rdy3
  - rdy1 = !v1 || rdy2
  - in_ready = rdy1 (combinational ready chain; no combinational path from in_valid to out_valid).
- Latency: exactly 3 cycles from acceptance to out_valid with out_ready held 1. Throughput is 1 sample/cycle.
- Output stability: while out_valid && !out_ready, all out_* hold stable and no sample is lost or duplicated.
- Stage 1 (sign/magnitude):
  - S = in_data MSB; mag = |in_data| in DATA_W-1 bits.
  - Most-negative input (-2^(DATA_W-1)) sets mag = 2^(DATA_W-1)-1 and sat = 1.
  - in_rnd travels with the sample.
- Stage 2 (normalise):
  - p = index of highest set bit of mag (mag=0 gives p=0).
  - E = max(0, p-(MANT_W-1)).
  - F = mag>>E, low MANT_W bits.
  - rbit = mag[E-1] if E>0, else 0.
- Stage 3 (round):
  - If in_rnd && rbit: F = F+1.
  - If that carries out of MANT_W bits: F = 2^(MANT_W-1) and E = E+1.
  - If E was already 2^EXP_W-1: F = all ones, E = max, sat = 1.
  - Truncate mode never rounds.
- Zero input gives S=0, E=0, F=0.
- Sign is preserved for all nonzero inputs; rounding never changes S.
- sat_cnt:
  - Increments by 1 on each output transfer with out_sat=1; saturates at 2^CNT_W-1.
  - sat_clr has priority: if sat_clr and a saturated transfer occur in the same cycle, sat_cnt = 0.

Decomposition:
- Shared package fpcvt_pkg:
  - Constant EMAX = 2^EXP_W-1.
  - Stage payload struct type holding s, mag/e/f, rbit, rnd, sat.
  - Function msb_index(mag) that returns p.
- One natural sub-module: fpcvt_lzd, a combinational priority encoder of width DATA_W-1 used in stage 2.

Test Plan (defaults DATA_W=12, EXP_W=3, MANT_W=4):
- Basic conversion, out_ready=1, rnd=1:
  - in 45 -> S0 E2 F11 after exactly 3 cycles.
  - in 46 -> S0 E2 F12.
  - in -46 -> S1 E2 F12.
  - in 7 -> S0 E0 F7.
  - in 0 -> S0 E0 F0.
- Rounding carry: in 125, rnd=1 -> E4 F8.
- Rounding mode: in 125, rnd=0 -> E3 F15.
- Saturation:
  - in 2047, rnd=1 -> E7 F15 sat=1.
  - in -2048 -> S1 E7 F15 sat=1.
  - sat_cnt = 2 after both are consumed.
  - sat_clr in the same cycle as a third saturated transfer -> sat_cnt = 0.
- Backpressure:
  - Stream 10 back-to-back samples, out_ready=0 for cycles 4-8 -> in_ready drops once 3 samples are held.
  - Output holds the first result stable throughout.
  - All 10 results emerge in order with none lost or duplicated.
  - In the out_ready=1 region, throughput is 1 result/cycle.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid=0 and sat_cnt=0 immediately (asynchronously). No stale sample appears after release.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared constants and helpers for the integer-to-compact-float converter.
package fpcvt_pkg;

    // Default geometry: 12-bit samples into a 1/3/4 sign/exponent/mantissa float.
    localparam int DATA_W_DEF = 12;
    localparam int EXP_W_DEF  = 3;
    localparam int MANT_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    // Largest magnitude the priority encoder helper can scan.
    localparam int MAX_MAG_W  = 64;

    // Largest exponent code at the default exponent width.
    localparam int EMAX       = (2 ** EXP_W_DEF) - 1;

    // Largest exponent code for an arbitrary exponent width.
    function automatic int emax_of(input int exp_w);
        return (2 ** exp_w) - 1;
    endfunction

    // Index of the highest set bit; an all-zero magnitude reports 0.
    function automatic int msb_index(input logic [MAX_MAG_W-1:0] mag);
        int p;
        p = 0;
        for (int i = 0; i < MAX_MAG_W; i++) begin
            if (mag[i]) begin
                p = i;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fpcvt_lzd.sv
// Combinational priority encoder: position of the highest set magnitude bit.
module fpcvt_lzd
    import fpcvt_pkg::*;
#(
    parameter int W  = 11,
    parameter int PW = 4
) (
    input  logic [W-1:0]  mag_i,
    output logic [PW-1:0] p_o
);

    // Zero-extend into the helper's scan width; the upper bits never win.
    assign p_o = PW'(msb_index(MAX_MAG_W'(mag_i)));

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage streaming converter from two's-complement integers to (S, E, F)
// floats with per-sample round/truncate, backpressure and saturation counting.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [EXP_W-1:0]  out_e,
    output logic [MANT_W-1:0] out_f,
    output logic              out_sat,
    output logic [CNT_W-1:0]  sat_cnt,
    input  logic              sat_clr
);

    localparam int MAG_W = DATA_W - 1;
    localparam int PW    = $clog2(MAG_W);
    localparam logic [EXP_W-1:0] EMAX_E = {EXP_W{1'b1}};

    // Reject geometries whose exponent cannot reach the top magnitude bit.
    if (DATA_W - 1 - MANT_W > emax_of(EXP_W)) begin : g_exp_range_err
        $error("fpcvt_pipe: EXP_W too small for DATA_W/MANT_W");
    end
    if (DATA_W < MANT_W + 2 || MANT_W < 2 || EXP_W < 2 || MAG_W > MAX_MAG_W) begin : g_geom_err
        $error("fpcvt_pipe: unsupported DATA_W/EXP_W/MANT_W combination");
    end

    // Stage payloads; widths follow the module parameters.
    typedef struct packed {
        logic             s;
        logic [MAG_W-1:0] mag;
        logic             rnd;
        logic             sat;
    } s1_t;

    typedef struct packed {
        logic              s;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
        logic              rbit;
        logic              rnd;
        logic              sat;
    } s2_t;

    logic              v1_q, v2_q, v3_q;
    logic              rdy1_s, rdy2_s, rdy3_s;
    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic [DATA_W-1:0] abs_s;
    logic [PW-1:0]     p_s;
    int                e_int_s;
    logic [MANT_W:0]   f_inc_s;
    logic              out_s_d, out_s_q;
    logic [EXP_W-1:0]  out_e_d, out_e_q;
    logic [MANT_W-1:0] out_f_d, out_f_q;
    logic              out_sat_d, out_sat_q;
    logic              xfer_s;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    // Ready ripples back from the consumer; a stage accepts when empty or draining.
    assign rdy3_s   = !v3_q || out_ready;
    assign rdy2_s   = !v2_q || rdy3_s;
    assign rdy1_s   = !v1_q || rdy2_s;
    assign in_ready = rdy1_s;

    // Stage 1 datapath: split sign and magnitude; the most-negative code clamps.
    always_comb begin
        s1_d = '0;
        if (in_data[DATA_W-1]) begin
            abs_s = ~in_data + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            abs_s = in_data;
        end
        s1_d.s   = in_data[DATA_W-1];
        s1_d.rnd = in_rnd;
        // Only -2^(DATA_W-1) still has the top bit set after negation.
        s1_d.sat = abs_s[DATA_W-1];
        if (abs_s[DATA_W-1]) begin
            s1_d.mag = {MAG_W{1'b1}};
        end else begin
            s1_d.mag = abs_s[MAG_W-1:0];
        end
    end

    // Stage 1 register: capture an accepted sample, advance when downstream allows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (rdy1_s) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    fpcvt_lzd #(
        .W  (MAG_W),
        .PW (PW)
    ) u_lzd (
        .mag_i (s1_q.mag),
        .p_o   (p_s)
    );

    // Stage 2 datapath: pick the exponent that fits the magnitude in MANT_W bits.
    always_comb begin
        s2_d = '0;
        if (int'(p_s) > MANT_W - 1) begin
            e_int_s = int'(p_s) - (MANT_W - 1);
        end else begin
            e_int_s = 0;
        end
        s2_d.s   = s1_q.s;
        s2_d.e   = EXP_W'(e_int_s);
        s2_d.f   = MANT_W'(s1_q.mag >> e_int_s);
        s2_d.rnd = s1_q.rnd;
        s2_d.sat = s1_q.sat;
        // Round bit is the first bit shifted out, absent when nothing was shifted.
        if (e_int_s > 0) begin
            s2_d.rbit = 1'(s1_q.mag >> (e_int_s - 1));
        end else begin
            s2_d.rbit = 1'b0;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            s2_q <= '0;
        end else if (rdy2_s) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_q <= s2_d;
            end
        end
    end

    // Stage 3 datapath: optional half-up rounding with renormalise or clamp on carry.
    always_comb begin
        f_inc_s   = {1'b0, s2_q.f} + {{MANT_W{1'b0}}, (s2_q.rnd & s2_q.rbit)};
        out_s_d   = s2_q.s;
        out_e_d   = s2_q.e;
        out_f_d   = f_inc_s[MANT_W-1:0];
        out_sat_d = s2_q.sat;
        if (f_inc_s[MANT_W]) begin
            if (s2_q.e == EMAX_E) begin
                out_e_d   = EMAX_E;
                out_f_d   = {MANT_W{1'b1}};
                out_sat_d = 1'b1;
            end else begin
                out_e_d   = s2_q.e + {{(EXP_W-1){1'b0}}, 1'b1};
                out_f_d   = {1'b1, {(MANT_W-1){1'b0}}};
                out_sat_d = s2_q.sat;
            end
        end else begin
            out_e_d   = s2_q.e;
            out_f_d   = f_inc_s[MANT_W-1:0];
            out_sat_d = s2_q.sat;
        end
    end

    // Stage 3 register doubles as the output register; it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q      <= 1'b0;
            out_s_q   <= 1'b0;
            out_e_q   <= '0;
            out_f_q   <= '0;
            out_sat_q <= 1'b0;
        end else if (rdy3_s) begin
            v3_q <= v2_q;
            if (v2_q) begin
                out_s_q   <= out_s_d;
                out_e_q   <= out_e_d;
                out_f_q   <= out_f_d;
                out_sat_q <= out_sat_d;
            end
        end
    end

    assign xfer_s = v3_q && out_ready;

    // Saturation count: clear wins, otherwise count delivered saturated results.
    always_comb begin
        if (sat_clr) begin
            cnt_d = '0;
        end else if (xfer_s && out_sat_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Saturation count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v3_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = cnt_q;

endmodule
